// File: rtl/freq_scan_reader_if.sv
// Symbol stream from freq_scan_reader to the Huffman tree builder.
// The master side presents (sym_id, sym_count) pairs under sym_valid.
// The slave side accepts a pair by raising sym_ready.
`timescale 1ns/1ps
interface freq_scan_reader_if #(
  parameter int SW = 20
);
  logic          sym_valid;
  logic          sym_ready;
  logic [7:0]    sym_id;
  logic [SW-1:0] sym_count;

  modport master (
    output sym_valid,
    output sym_id,
    output sym_count,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_id,
    input  sym_count,
    output sym_ready
  );
endinterface

// File: rtl/freq_scan_reader.sv
// Read-side controller for the 4-lane byte frequency statistics RAM.
// The controller sweeps symbols 0..255 two at a time, one even/odd pair per read.
// It sums the four lane counts of each symbol and pushes the results into a small FIFO.
// The FIFO has two write ports and one read port. It feeds the symbol stream interface
// in ascending symbol order.
// A read is only issued when the FIFO is guaranteed to have room for its two results.
// The FIFO therefore never overflows, whatever the downstream stalls are.
// Optional feature: define FREQ_ZERO_SKIP_EN to drop symbols whose summed count is zero.
`timescale 1ns/1ps
module freq_scan_reader #(
  parameter int FW         = 18,
  parameter int SW         = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start_i,
  input  logic                ram_busy_i,
  output logic                freq_oe_o,
  output logic [7:0]          freq_addr1a_o,
  output logic [7:0]          freq_addr2a_o,
  output logic [7:0]          freq_addr3a_o,
  output logic [7:0]          freq_addr4a_o,
  output logic [7:0]          freq_addr1b_o,
  output logic [7:0]          freq_addr2b_o,
  output logic [7:0]          freq_addr3b_o,
  output logic [7:0]          freq_addr4b_o,
  input  logic [FW-1:0]       freq_value1a_i,
  input  logic [FW-1:0]       freq_value2a_i,
  input  logic [FW-1:0]       freq_value3a_i,
  input  logic [FW-1:0]       freq_value4a_i,
  input  logic [FW-1:0]       freq_value1b_i,
  input  logic [FW-1:0]       freq_value2b_i,
  input  logic [FW-1:0]       freq_value3b_i,
  input  logic [FW-1:0]       freq_value4b_i,
  input  logic                freq_valid_i,
  freq_scan_reader_if.master  symIf,
  output logic                scan_busy_o,
  output logic                done_o,
  output logic [8:0]          nz_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t        state_q;
  logic [6:0]    k_q;
  logic [6:0]    inflightK_q;
  logic          inflight_q;
  logic          scanBusy_q;
  logic          done_q;
  logic [8:0]    nzCount_q;

  logic [7:0]    fifoId_q    [FIFO_DEPTH];
  logic [SW-1:0] fifoCount_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [CW-1:0] fifoCnt_q;
  logic [PW-1:0] wrPtr_d;
  logic [PW-1:0] rdPtr_d;
  logic [CW-1:0] fifoCnt_d;
  logic [PW-1:0] wrPtrB;

  logic          issue;
  logic          respValid;
  logic          pushA;
  logic          pushB;
  logic          popEn;
  logic [SW-1:0] sumA;
  logic [SW-1:0] sumB;

  function automatic logic [SW-1:0] extend(input logic [FW-1:0] v);
    return {{(SW-FW){1'b0}}, v};
  endfunction

  // Issue a read only while scanning and only if the FIFO can absorb its two results.
  // The two results of a read already in flight are counted against the free space as well.
  always_comb begin
    issue = (state_q == SCAN) &&
            ((int'(fifoCnt_q) + (inflight_q ? 2 : 0)) <= (FIFO_DEPTH - 2));
  end

  // Sum the lanes of the returning read and decide which of the two symbols get pushed.
  // A stray freq_valid with no read outstanding is ignored.
  always_comb begin
    sumA      = extend(freq_value1a_i) + extend(freq_value2a_i) +
                extend(freq_value3a_i) + extend(freq_value4a_i);
    sumB      = extend(freq_value1b_i) + extend(freq_value2b_i) +
                extend(freq_value3b_i) + extend(freq_value4b_i);
    respValid = freq_valid_i && inflight_q;
`ifdef FREQ_ZERO_SKIP_EN
    pushA     = respValid && (sumA != '0);
    pushB     = respValid && (sumB != '0);
`else
    pushA     = respValid;
    pushB     = respValid;
`endif
  end

  // Compute the next FIFO pointers and occupancy.
  // The odd entry lands right after the even one, or in its place if the even one was skipped.
  always_comb begin
    popEn     = (fifoCnt_q != '0) && symIf.sym_ready;
    wrPtrB    = wrPtr_q + PW'(pushA);
    wrPtr_d   = wrPtrB + PW'(pushB);
    rdPtr_d   = rdPtr_q + PW'(popEn);
    fifoCnt_d = fifoCnt_q + CW'(pushA) + CW'(pushB) - CW'(popEn);
  end

  // Hold the FIFO storage and pointers.
  // Entries are cleared on reset so the stream outputs come up as zero.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoId_q[i]    <= '0;
        fifoCount_q[i] <= '0;
      end
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      if (pushA) begin
        fifoId_q[wrPtr_q]    <= {inflightK_q, 1'b0};
        fifoCount_q[wrPtr_q] <= sumA;
      end
      if (pushB) begin
        fifoId_q[wrPtrB]    <= {inflightK_q, 1'b1};
        fifoCount_q[wrPtrB] <= sumB;
      end
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      fifoCnt_q <= fifoCnt_d;
    end
  end

  // Sweep control: track the pair index, the outstanding read, the busy/done flags and the emitted count.
  // SCAN moves to DRAIN once the last pair has been issued.
  // DRAIN waits until the FIFO is empty and no read is in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      k_q         <= '0;
      inflight_q  <= 1'b0;
      inflightK_q <= '0;
      scanBusy_q  <= 1'b0;
      done_q      <= 1'b0;
      nzCount_q   <= '0;
    end else begin
      inflight_q <= issue;
      done_q     <= 1'b0;
      if (issue) begin
        inflightK_q <= k_q;
      end
      if (popEn) begin
        nzCount_q <= nzCount_q + 9'd1;
      end
      case (state_q)
        IDLE: begin
          if (start_i && !ram_busy_i) begin
            state_q    <= SCAN;
            k_q        <= '0;
            scanBusy_q <= 1'b1;
            nzCount_q  <= '0;
          end
        end
        SCAN: begin
          if (issue) begin
            k_q <= k_q + 7'd1;
            if (k_q == 7'd127) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((fifoCnt_q == '0) && !inflight_q) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            scanBusy_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the RAM read port. Addresses are forced to zero whenever no read is issued.
  always_comb begin
    freq_oe_o     = issue;
    freq_addr1a_o = issue ? {k_q, 1'b0} : 8'd0;
    freq_addr2a_o = freq_addr1a_o;
    freq_addr3a_o = freq_addr1a_o;
    freq_addr4a_o = freq_addr1a_o;
    freq_addr1b_o = issue ? {k_q, 1'b1} : 8'd0;
    freq_addr2b_o = freq_addr1b_o;
    freq_addr3b_o = freq_addr1b_o;
    freq_addr4b_o = freq_addr1b_o;
  end

  // Present the FIFO head on the symbol stream, together with the status outputs.
  always_comb begin
    symIf.sym_valid = (fifoCnt_q != '0);
    symIf.sym_id    = fifoId_q[rdPtr_q];
    symIf.sym_count = fifoCount_q[rdPtr_q];
    scan_busy_o     = scanBusy_q;
    done_o          = done_q;
    nz_count_o      = nzCount_q;
  end

endmodule

// File: tb/tb_freq_scan_reader.sv
// Self-checking bench for freq_scan_reader.
// A behavioural RAM model answers the reads. The expected stream for each sweep is computed
// from the RAM contents with plain arithmetic and queued. A monitor process pops the queue
// whenever the DUT hands over a pair.
// Define FREQ_ZERO_SKIP_EN on both RTL and bench to exercise the zero-skip build.
`timescale 1ns/1ps
module tb_freq_scan_reader;

  localparam int FW         = 18;
  localparam int SW         = 20;
  localparam int FIFO_DEPTH = 4;
`ifdef FREQ_ZERO_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic          ramBusy = 1'b0;
  logic          freqOe;
  logic [7:0]    addrA [4];
  logic [7:0]    addrB [4];
  logic [FW-1:0] ramVal [8];
  logic          ramValid = 1'b0;
  logic          spurious = 1'b0;
  logic          symReady = 1'b1;
  logic          scanBusy;
  logic          doneO;
  logic [8:0]    nzCount;

  logic [FW-1:0] ram [4][256];
  logic [27:0]   expQ [$];
  int            pairEnt [128];
  int            expNz;
  int            nextK;
  int            entries;
  int            pops;
  int            readyMode = 0;
  int            passCount = 0;
  int            checkCount = 0;

  freq_scan_reader_if #(.SW(SW)) symIf ();
  assign symIf.sym_ready = symReady;

  freq_scan_reader #(.FW(FW), .SW(SW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .start_i        (start),
    .ram_busy_i     (ramBusy),
    .freq_oe_o      (freqOe),
    .freq_addr1a_o  (addrA[0]),
    .freq_addr2a_o  (addrA[1]),
    .freq_addr3a_o  (addrA[2]),
    .freq_addr4a_o  (addrA[3]),
    .freq_addr1b_o  (addrB[0]),
    .freq_addr2b_o  (addrB[1]),
    .freq_addr3b_o  (addrB[2]),
    .freq_addr4b_o  (addrB[3]),
    .freq_value1a_i (ramVal[0]),
    .freq_value2a_i (ramVal[1]),
    .freq_value3a_i (ramVal[2]),
    .freq_value4a_i (ramVal[3]),
    .freq_value1b_i (ramVal[4]),
    .freq_value2b_i (ramVal[5]),
    .freq_value3b_i (ramVal[6]),
    .freq_value4b_i (ramVal[7]),
    .freq_valid_i   (ramValid),
    .symIf          (symIf),
    .scan_busy_o    (scanBusy),
    .done_o         (doneO),
    .nz_count_o     (nzCount)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Statistics RAM model: one-cycle read latency, each lane served from its own address
  always @(posedge clk) begin
    ramValid <= freqOe | spurious;
    for (int l = 0; l < 4; l++) begin
      ramVal[l]     <= ram[l][addrA[l]];
      ramVal[l + 4] <= ram[l][addrB[l]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Fill the RAM: 0 = all zero, 1 = only 'A' populated, 2 = random with max lanes at 0xFF, 3 = random
  task automatic loadRam(input int pattern);
    for (int s = 0; s < 256; s++) begin
      bit symZero;
      symZero = ($urandom_range(0, 3) == 0);
      for (int l = 0; l < 4; l++) begin
        int r;
        r = $urandom_range(0, 7);
        if (pattern <= 1 || symZero) begin
          ram[l][s] = '0;
        end else if (r == 0) begin
          ram[l][s] = '0;
        end else if (r == 1) begin
          ram[l][s] = {FW{1'b1}};
        end else begin
          ram[l][s] = FW'($urandom_range(0, 5000));
        end
      end
    end
    if (pattern == 1) begin
      ram[0][8'h41] = 18'd3;
      ram[1][8'h41] = 18'd5;
      ram[2][8'h41] = 18'd0;
      ram[3][8'h41] = 18'd1;
    end
    if (pattern == 2) begin
      for (int l = 0; l < 4; l++) begin
        ram[l][8'hFF] = {FW{1'b1}};
      end
    end
  endtask

  // Build the expected stream from the RAM contents, then pulse start
  task automatic applyStimulus();
    expQ.delete();
    expNz   = 0;
    nextK   = 0;
    entries = 0;
    pops    = 0;
    for (int k = 0; k < 128; k++) begin
      pairEnt[k] = 0;
    end
    for (int s = 0; s < 256; s++) begin
      logic [SW-1:0] sum;
      sum = SW'(ram[0][s]) + SW'(ram[1][s]) + SW'(ram[2][s]) + SW'(ram[3][s]);
      if (!(SKIP_ON && sum == '0)) begin
        expQ.push_back({8'(s), sum});
        expNz++;
        pairEnt[s / 2]++;
      end
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (doneO) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({tag, "_queue_empty"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_nz_count"}, 64'(nzCount), 64'(expNz));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(doneO), 64'd0);
    checkOutput({tag, "_busy_clear"}, 64'(scanBusy), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_freq_oe"}, 64'(freqOe), 64'd0);
    checkOutput({tag, "_addr"}, {addrA[0], addrA[1], addrA[2], addrA[3],
                                 addrB[0], addrB[1], addrB[2], addrB[3]}, 64'd0);
    checkOutput({tag, "_sym_valid"}, 64'(symIf.sym_valid), 64'd0);
    checkOutput({tag, "_sym_id"}, 64'(symIf.sym_id), 64'd0);
    checkOutput({tag, "_sym_count"}, 64'(symIf.sym_count), 64'd0);
    checkOutput({tag, "_scan_busy"}, 64'(scanBusy), 64'd0);
    checkOutput({tag, "_done"}, 64'(doneO), 64'd0);
    checkOutput({tag, "_nz_count"}, 64'(nzCount), 64'd0);
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = toggle every 3 cycles, 2 = random
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: begin
          phase++;
          if (phase >= 3) begin
            phase    = 0;
            symReady = !symReady;
          end
        end
        2: symReady = 1'($urandom_range(0, 1));
        default: symReady = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, read addresses and FIFO space bound
  initial begin
    bit            stalled;
    logic [27:0]   held;
    logic [27:0]   exp;
    logic [7:0]    eA;
    logic [7:0]    eB;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall_hold", {35'd0, symIf.sym_valid, symIf.sym_id, symIf.sym_count},
                      {35'd0, 1'b1, held});
        end
        if (freqOe) begin
          checkOutput("read_index_range", 64'(nextK < 128), 64'd1);
          eA = 8'(2 * nextK);
          eB = 8'(2 * nextK + 1);
          checkOutput("read_addr", {addrA[0], addrA[1], addrA[2], addrA[3],
                                    addrB[0], addrB[1], addrB[2], addrB[3]},
                      {eA, eA, eA, eA, eB, eB, eB, eB});
          entries += pairEnt[nextK % 128];
          nextK++;
          checkOutput("fifo_space", 64'(entries - pops <= FIFO_DEPTH), 64'd1);
        end
        if (symIf.sym_valid && symReady) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_pair", {36'd0, symIf.sym_id, symIf.sym_count}, 64'hFFFF_FFFF);
          end else begin
            exp = expQ.pop_front();
            checkOutput("pair", {36'd0, symIf.sym_id, symIf.sym_count}, {36'd0, exp});
          end
          checkOutput("busy_during_output", 64'(scanBusy), 64'd1);
          pops++;
        end
        stalled = symIf.sym_valid && !symReady;
        held    = {symIf.sym_id, symIf.sym_count};
      end
    end
  end

  // Directed sequence of sweeps
  initial begin
    bit found;
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < 256; s++) ram[l][s] = '0;
    end
    #3;
    checkResetValues("reset");
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    $display("[TB] all-zero RAM, always ready");
    loadRam(0);
    readyMode = 0;
    applyStimulus();
    waitDone("zero");

    $display("[TB] single symbol 'A'");
    loadRam(1);
    applyStimulus();
    waitDone("sym_A");

    $display("[TB] max lanes at 0xFF, random ready");
    loadRam(2);
    readyMode = 2;
    applyStimulus();
    waitDone("max");

    $display("[TB] stray freq_valid while idle");
    readyMode = 0;
    @(posedge clk);
    #1 spurious = 1'b1;
    @(posedge clk);
    #1 spurious = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stray_valid_ignored", 64'(symIf.sym_valid), 64'd0);
    end

    $display("[TB] ready toggling every 3 cycles");
    loadRam(3);
    readyMode = 1;
    applyStimulus();
    waitDone("toggle");

    $display("[TB] start while RAM busy, then restart attempt mid-sweep");
    readyMode = 0;
    @(posedge clk);
    #1 ramBusy = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_start_ignored", 64'(scanBusy), 64'd0);
    checkOutput("busy_start_no_read", 64'(freqOe), 64'd0);
    #1 ramBusy = 1'b0;
    loadRam(3);
    readyMode = 2;
    applyStimulus();
    repeat (20) @(posedge clk);
    #1 ramBusy = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ramBusy = 1'b0;
    waitDone("restart_ignored");

    $display("[TB] reset at pair 40");
    loadRam(3);
    readyMode = 1;
    applyStimulus();
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (freqOe && addrA[0] == 8'd80) found = 1'b1;
    end
    checkOutput("reached_pair_40", 64'(found), 64'd1);
    #2 rstN = 1'b0;
    #1;
    checkResetValues("mid_reset");
    expQ.delete();
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    readyMode = 0;
    applyStimulus();
    waitDone("after_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
